ternary_dual_hazard_tracker: RTL
================================

# ternary_dual_hazard_tracker

Tracks destination-register tags for both issue slots of the dual-issue ternary pipeline through EX, MEM and WB. It produces the `ex_*`, `mem_*` and `wb_*` rd/reg_write tags that drive the dual forwarding unit. It also detects load-use hazards between the EX stage and the pair currently in ID, and inserts one-cycle bubbles for them. It sits between decode/issue and the dual forwarding unit, and is the only source of those tags.

## Interface
Parameters:
- `STAT_W`, 16: width of the stall-statistics counter.

Ports. Addresses are `trit_t [2:0]` from `ternary_pkg`. R0 is the all-`T_ZERO` address.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid_a`, `id_valid_b`  in  1  ID-stage slot holds a real instruction.
- `id_rd_a`, `id_rd_b`  in  trit_t[2:0]  ID destination.
- `id_reg_write_a`, `id_reg_write_b`  in  1  ID instruction writes rd.
- `id_mem_read_a`, `id_mem_read_b`  in  1  ID instruction is a load.
- `id_rs1_a`, `id_rs2_a`, `id_rs1_b`, `id_rs2_b`  in  trit_t[2:0]  ID source addresses.
- `mem_ready`  in  1  1 = pipeline advances this cycle; 0 = memory freeze.
- `flush`  in  1  kill the ID pair (branch redirect).
- `ex_rd_a`, `ex_rd_b`  out  trit_t[2:0]  EX-stage tags.
- `ex_reg_write_a`, `ex_reg_write_b`  out  1  EX write enables, masked for loads (see Operation).
- `mem_rd_a`, `mem_rd_b`, `mem_reg_write_a`, `mem_reg_write_b`  out  MEM tags.
- `wb_rd_a`, `wb_rd_b`, `wb_reg_write_a`, `wb_reg_write_b`  out  WB tags.
- `load_use_stall`  out  1  hold fetch/ID this cycle.
- `stall_count`  out  STAT_W  count of cycles with `load_use_stall` asserted.

## Operation
- Three register stages per slot: EX, MEM, WB. Each stage holds rd, reg_write and mem_read.
- Bubble: reg_write=0, mem_read=0, rd=R0.
- Advance (`mem_ready`=1):
  - WB←MEM and MEM←EX.
  - EX←ID when not stalled and not flushed. A slot with `id_valid`=0 enters EX as a bubble.
  - EX←bubble (both slots) when `load_use_stall`=1 or `flush`=1.
- Freeze (`mem_ready`=0): all stages hold.
  - Exception: `flush` still bubbles EX.
  - `load_use_stall` is still computed.
- A load-use hazard exists when an EX slot X has mem_read=1, reg_write=1 and rd≠R0, and rd matches any rs1/rs2 of a valid ID slot.
- `load_use_stall` = hazard && !flush. It is combinational from the EX registers and the ID inputs.
- The ID pair is never split by this block. Issue logic guarantees that ID slot B does not source ID slot A's load destination.
- `ex_reg_write_a` output = EX_A reg_write && !EX_A mem_read.
  - Load data is not available in EX, so EX_A→B forwarding must never select a load.
  - `ex_reg_write_b` is masked the same way.
- MEM/WB reg_write outputs are unmasked.
- A stall lasts exactly one advancing cycle: the load moves to MEM, the hazard clears, and the pair enters EX.
- If `mem_ready`=0, the stall persists until the pipeline advances.

## Timing
- Reset: every stage is a bubble. All rd outputs are R0, all reg_write outputs are 0, `load_use_stall`=0, `stall_count`=0.
- Latency of an ID instruction accepted at edge N:
  - EX tags are valid after edge N.
  - MEM tags are valid after edge N+1.
  - WB tags are valid after edge N+2, assuming no freeze.
- Each freeze cycle adds one cycle to these latencies.
- `load_use_stall` has zero latency (same cycle as the hazard).
- Simultaneous `flush` and hazard: flush wins. Stall=0 and EX is bubbled.
- `rst` overrides `mem_ready`, `flush` and any stall in the same cycle.

## Configuration
- `TRITONE_HAZARD_STATS_EN` defined:
  - `stall_count` increments on every cycle with `load_use_stall`=1.
  - It saturates at all-ones and clears only on `rst`.
- Not defined: no counter logic; `stall_count` is tied to 0.

## Test plan
- Load then dependent op:
  - Stimulus: cycle 0 ID_A = load rd=(+,0,0); cycle 1 ID_B rs1=(+,0,0), `mem_ready`=1.
  - Required: `load_use_stall`=1 for exactly cycle 1; EX is a bubble in cycle 2; the dependent op reaches EX in cycle 3.
  - With stats enabled: `stall_count`=1.
- Load to R0:
  - Stimulus: load rd=R0 followed by an op reading R0.
  - Required: no stall; `ex_reg_write_a`=0 for the load while it is in EX.
- Freeze during stall:
  - Stimulus: hazard present, `mem_ready`=0 for 3 cycles.
  - Required: stall held high for all 3 cycles; all tags constant; stall drops one cycle after `mem_ready` returns to 1.
- Flush with hazard:
  - Stimulus: `flush`=1 and hazard in the same cycle.
  - Required: `load_use_stall`=0; next-cycle EX tags have reg_write=0 and rd=R0.
- Pipeline walk:
  - Stimulus: ALU pair A rd=(-,+,0), B rd=(0,0,+), both writes.
  - Required: tags appear on ex_*, then mem_*, then wb_* on three consecutive cycles; `ex_reg_write_a`=1.
- Reset mid-stream:
  - Stimulus: assert `rst` with all stages full.
  - Required: the next cycle shows all outputs at their reset values.

Source files
------------

// File: rtl/ternary_dual_hazard_tracker.sv
// ternary_dual_hazard_tracker
// Carries destination-register tags for both issue slots through EX, MEM and
// WB, feeding the dual forwarding unit. Detects load-use hazards between the
// loads sitting in EX and the pair in ID, and bubbles EX for one advancing
// cycle when one is found.
// Optional build macro: TRITONE_HAZARD_STATS_EN enables the saturating
// stall_count statistic; without it stall_count is tied to zero.

package ternary_pkg;
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO = 2'b00;
  localparam trit_t T_POS  = 2'b01;
  localparam trit_t T_NEG  = 2'b10;
endpackage

module ternary_dual_hazard_tracker
  import ternary_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_a,
  input  logic              id_valid_b,
  input  trit_t [2:0]       id_rd_a,
  input  trit_t [2:0]       id_rd_b,
  input  logic              id_reg_write_a,
  input  logic              id_reg_write_b,
  input  logic              id_mem_read_a,
  input  logic              id_mem_read_b,
  input  trit_t [2:0]       id_rs1_a,
  input  trit_t [2:0]       id_rs2_a,
  input  trit_t [2:0]       id_rs1_b,
  input  trit_t [2:0]       id_rs2_b,
  input  logic              mem_ready,
  input  logic              flush,
  output trit_t [2:0]       ex_rd_a,
  output trit_t [2:0]       ex_rd_b,
  output logic              ex_reg_write_a,
  output logic              ex_reg_write_b,
  output trit_t [2:0]       mem_rd_a,
  output trit_t [2:0]       mem_rd_b,
  output logic              mem_reg_write_a,
  output logic              mem_reg_write_b,
  output trit_t [2:0]       wb_rd_a,
  output trit_t [2:0]       wb_rd_b,
  output logic              wb_reg_write_a,
  output logic              wb_reg_write_b,
  output logic              load_use_stall,
  output logic [STAT_W-1:0] stall_count
);

  // One pipeline stage worth of tag state for a single slot.
  typedef struct packed {
    trit_t [2:0] rd;
    logic        reg_write;
    logic        mem_read;
  } stage_t;

  localparam trit_t [2:0] R0 = {T_ZERO, T_ZERO, T_ZERO};
  localparam stage_t BUBBLE = '{rd: R0, reg_write: 1'b0, mem_read: 1'b0};

  // ID pair gathered into slot-indexed arrays so both slots share one body.
  stage_t      id_stage [2];
  logic        id_valid [2];
  trit_t [2:0] id_rs1   [2];
  trit_t [2:0] id_rs2   [2];

  assign id_stage[0] = '{rd: id_rd_a, reg_write: id_reg_write_a, mem_read: id_mem_read_a};
  assign id_stage[1] = '{rd: id_rd_b, reg_write: id_reg_write_b, mem_read: id_mem_read_b};
  assign id_valid[0] = id_valid_a;
  assign id_valid[1] = id_valid_b;
  assign id_rs1[0]   = id_rs1_a;
  assign id_rs1[1]   = id_rs1_b;
  assign id_rs2[0]   = id_rs2_a;
  assign id_rs2[1]   = id_rs2_b;

  // Per EX slot: does its load feed any source of a valid ID instruction.
  logic [1:0] ex_load_hit;

  // A flush kills the ID pair anyway, so it suppresses the stall request.
  assign load_use_stall = (|ex_load_hit) && !flush;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    stage_t ex_reg,  ex_next;
    stage_t mem_reg, mem_next;
    stage_t wb_reg,  wb_next;
    logic   ex_is_live_load;
    logic   src_hit_a;
    logic   src_hit_b;

    // Loads targeting R0 never produce a value anyone waits for.
    assign ex_is_live_load = ex_reg.mem_read && ex_reg.reg_write && (ex_reg.rd != R0);
    assign src_hit_a = id_valid[0] && ((id_rs1[0] == ex_reg.rd) || (id_rs2[0] == ex_reg.rd));
    assign src_hit_b = id_valid[1] && ((id_rs1[1] == ex_reg.rd) || (id_rs2[1] == ex_reg.rd));
    assign ex_load_hit[gi] = ex_is_live_load && (src_hit_a || src_hit_b);

    // Next-stage selection: shift on advance, hold on freeze, flush always bubbles EX.
    always_comb begin
      ex_next  = ex_reg;
      mem_next = mem_reg;
      wb_next  = wb_reg;
      if (mem_ready) begin
        wb_next  = mem_reg;
        mem_next = ex_reg;
        if (load_use_stall || flush || !id_valid[gi]) begin
          ex_next = BUBBLE;
        end else begin
          ex_next = id_stage[gi];
        end
      end else if (flush) begin
        ex_next = BUBBLE;
      end
    end

    // Stage registers; reset empties the whole pipe regardless of other controls.
    always_ff @(posedge clk) begin
      if (rst) begin
        ex_reg  <= BUBBLE;
        mem_reg <= BUBBLE;
        wb_reg  <= BUBBLE;
      end else begin
        ex_reg  <= ex_next;
        mem_reg <= mem_next;
        wb_reg  <= wb_next;
      end
    end
  end

  // EX write enables hide loads: their data does not exist yet in EX, so the
  // forwarding unit must never pick them from this stage.
  assign ex_rd_a         = g_slot[0].ex_reg.rd;
  assign ex_rd_b         = g_slot[1].ex_reg.rd;
  assign ex_reg_write_a  = g_slot[0].ex_reg.reg_write && !g_slot[0].ex_reg.mem_read;
  assign ex_reg_write_b  = g_slot[1].ex_reg.reg_write && !g_slot[1].ex_reg.mem_read;
  assign mem_rd_a        = g_slot[0].mem_reg.rd;
  assign mem_rd_b        = g_slot[1].mem_reg.rd;
  assign mem_reg_write_a = g_slot[0].mem_reg.reg_write;
  assign mem_reg_write_b = g_slot[1].mem_reg.reg_write;
  assign wb_rd_a         = g_slot[0].wb_reg.rd;
  assign wb_rd_b         = g_slot[1].wb_reg.rd;
  assign wb_reg_write_a  = g_slot[0].wb_reg.reg_write;
  assign wb_reg_write_b  = g_slot[1].wb_reg.reg_write;

`ifdef TRITONE_HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_count_reg;

  // Saturating count of stalled cycles, frozen cycles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if (load_use_stall && !(&stall_count_reg)) begin
      stall_count_reg <= stall_count_reg + STAT_W'(1);
    end
  end

  assign stall_count = stall_count_reg;
`else
  assign stall_count = '0;
`endif

endmodule
